// File: rtl/pc_fetch_unit.sv
// KGP-miniRISC program counter and instruction-fetch sequencer (IDLE/FETCH/WAIT/HOLD/HALTED).
// Optional fetch timeout compiled in with `define FETCH_TIMEOUT_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_addr,
    input  logic        pc_we,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [31:0] pc,
    output logic [31:0] nextPC,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        halted,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_HALTED
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        req_q;
    logic        instr_valid_q;
    logic        halted_q;
    logic        fetch_err_q;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] tmo_cnt_q;
`else
    logic unused_timeout_param;
    assign unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            req_q         <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fetch_err_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_q     <= '0;
`endif
        end else begin
            // The request strobe is raised only on the edge that enters FETCH.
            req_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                end
                S_FETCH: begin
                    state_q   <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr_q       <= imem_rdata;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_HOLD;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (tmo_cnt_q + 8'd1 == TMO_LIMIT) begin
                        fetch_err_q <= 1'b1;
                        halted_q    <= 1'b1;
                        state_q     <= S_HALTED;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
`endif
                end
                S_HOLD: begin
                    // Halt has priority over a simultaneous commit.
                    if (halt) begin
                        instr_valid_q <= 1'b0;
                        halted_q      <= 1'b1;
                        state_q       <= S_HALTED;
                    end else if (pc_we) begin
                        pc_q          <= next_addr;
                        instr_valid_q <= 1'b0;
                        req_q         <= 1'b1;
                        state_q       <= S_FETCH;
                    end
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign nextPC      = pc_q + 32'd1;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err   = fetch_err_q;
`else
    assign fetch_err   = 1'b0;
    logic unused_fetch_err;
    assign unused_fetch_err = fetch_err_q;
`endif

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for KGP-miniRISC, directly downstream of the next-address selection logic.
- Registers the selected next address as PC, exports nextPC (PC+1, word-addressed) back to that logic, fetches the instruction at PC over a request/valid memory interface, and holds it for decode until the core commits.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 15, max WAIT cycles before a fetch error (used only with the optional feature); range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- next_addr  in  32  selected next PC; sampled only on an accepted pc_we.
- pc_we  in  1  commit pulse: current instruction retired, load next_addr.
- halt  in  1  decoded halt; stop fetching.
- imem_req  out  1  one-cycle memory read request.
- imem_addr  out  32  read address, equal to pc.
- imem_rdata  in  32  read data.
- imem_rvalid  in  1  imem_rdata valid this cycle.
- pc  out  32  current PC register.
- nextPC  out  32  pc + 1, combinational, modulo 2^32.
- instr  out  32  held instruction.
- instr_valid  out  1  instr is valid for the current pc.
- halted  out  1  unit is in HALTED.
- fetch_err  out  1  fetch timed out (optional feature only; tie to 0 otherwise).

Behaviour:
- Reset, asynchronous on rst=0:
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, halted=0, fetch_err=0, timeout counter=0.
- State IDLE: entered after reset release; moves to FETCH on the next edge.
- State FETCH:
  - imem_req=1 and imem_addr=pc for exactly one cycle.
  - Moves to WAIT.
- State WAIT:
  - imem_req=0.
  - On imem_rvalid=1: instr<=imem_rdata, instr_valid<=1, move to HOLD.
  - Memory latency is unbounded unless the optional feature is compiled in.
- State HOLD: instr and instr_valid stay stable.
  - halt=1: move to HALTED, instr_valid<=0, pc unchanged. Halt beats pc_we when both are high in the same cycle.
  - Else pc_we=1: pc<=next_addr, instr_valid<=0, move to FETCH. The new address is fetched the following cycle.
- State HALTED:
  - halted=1, no requests issued.
  - Exit only through reset.
- Ignored inputs:
  - pc_we and halt are ignored outside HOLD.
  - imem_rvalid is ignored outside WAIT, so a stale response after reset or in HOLD has no effect.
- Arithmetic and timing:
  - nextPC = pc + 1 with natural 32-bit wrap: 32'hFFFF_FFFF -> 32'h0000_0000.
  - No shifting or alignment is applied to next_addr.
  - Minimum latency: rst released -> IDLE (1 cycle) -> FETCH (req) -> WAIT; with rvalid in the first WAIT cycle, instr_valid=1 on the 3rd edge after release.
  - Steady-state throughput with 1-cycle memory: one instruction per 3 cycles (FETCH, WAIT, HOLD with immediate pc_we).
- Reset mid-operation: any state returns to IDLE immediately; pc=RESET_PC; an outstanding request is abandoned.
- All outputs except nextPC are registered.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without imem_rvalid.
  - If it reaches TIMEOUT_CYCLES without imem_rvalid: fetch_err<=1 (sticky until reset), move to HALTED, halted=1, instr_valid stays 0.
  - If imem_rvalid arrives in the same cycle the count is reached, the data is accepted and no error is raised.
- Undefined: no counter logic; fetch_err tied to 0; WAIT waits indefinitely.

Test Plan:
- Reset with RESET_PC=0; memory returns 32'h1234_5678 one cycle after req -> imem_req at cycle 2 with addr 0; instr=32'h1234_5678, instr_valid=1 at cycle 3; nextPC=1.
- In HOLD, pc_we=1 with next_addr=32'h40 -> pc=32'h40, instr_valid drops the next cycle, then one-cycle req with imem_addr=32'h40; nextPC=32'h41.
- pc=32'hFFFF_FFFF -> nextPC=0; pc_we with next_addr=nextPC -> fetch from address 0.
- halt=1 and pc_we=1 together in HOLD (next_addr=32'h80) -> halted=1, pc unchanged, no further imem_req for 20 cycles, pc_we thereafter ignored.
- rst asserted in WAIT, imem_rvalid=1 with data 32'hDEAD_BEEF one cycle after release -> instr stays 0; fresh fetch from RESET_PC.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, memory never responds -> fetch_err=1 and halted=1 after 4 WAIT cycles. Repeat with rvalid exactly on the 4th cycle -> data accepted, fetch_err=0.
